// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter that lets two requesters stream bursts of consecutive
// words out of one shared combinational ROM over a valid/ready interface.
module rom_burst_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] start0,
  input  logic [ADDR_W-1:0] len0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] start1,
  input  logic [ADDR_W-1:0] len1,
  output logic              gnt1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_id,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state;
  logic [ADDR_W-1:0] count;
  logic              last_gnt;  // 1 when requester 1 was granted most recently

  assign out_data = rom_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rom_addr  <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      out_last  <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      busy      <= 1'b0;
      last_gnt  <= 1'b1;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last_gnt)) begin
            gnt0      <= 1'b1;
            rom_addr  <= start0;
            count     <= len0;
            out_id    <= 1'b0;
            out_last  <= (len0 == '0);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            last_gnt  <= 1'b0;
            state     <= STREAM;
          end else if (req1) begin
            gnt1      <= 1'b1;
            rom_addr  <= start1;
            count     <= len1;
            out_id    <= 1'b1;
            out_last  <= (len1 == '0);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            last_gnt  <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          // Without out_ready everything holds, keeping out_data stable.
          if (out_ready) begin
            if (count == '0) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              count    <= count - 1'b1;
              out_last <= (count == ADDR_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
